// File: rtl/input_map_pkg.sv
// Shared types and constants for the arcade control-input front end:
// control-index layout, keymap entry format and the built-in default keymap.
package input_map_pkg;

  localparam int CTRL_STRIDE = 8;
  localparam logic [5:0] CTRL_U    = 6'd0;
  localparam logic [5:0] CTRL_D    = 6'd1;
  localparam logic [5:0] CTRL_L    = 6'd2;
  localparam logic [5:0] CTRL_R    = 6'd3;
  localparam logic [5:0] CTRL_BTN0 = 6'd4;
  localparam logic [5:0] CTRL_BTN1 = 6'd5;
  localparam logic [5:0] CTRL_BTN2 = 6'd6;
  localparam logic [5:0] CTRL_BTN3 = 6'd7;

  localparam int COIN_W = 20;
  localparam int AF_W   = 22;

  typedef struct packed {
    logic       valid;
    logic       ext;
    logic [5:0] idx;
  } km_entry_t;

  // Bit order matches ps2_key[9:0] so a straight cast captures an event.
  typedef struct packed {
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } key_event_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_APPLY} scan_state_e;

  // Default targets are stored by group so they can be placed for any NUM_PLAYERS.
  typedef enum logic [1:0] {GRP_P0, GRP_START, GRP_COIN, GRP_SYS} dflt_grp_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    dflt_grp_e  grp;
    logic [2:0] sub;
  } dflt_entry_t;

  localparam int DEFAULT_N = 12;
  localparam dflt_entry_t DEFAULT_MAP [DEFAULT_N] = '{
    '{8'h16, 1'b0, GRP_START, 3'd0},
    '{8'h1E, 1'b0, GRP_START, 3'd1},
    '{8'h2E, 1'b0, GRP_COIN,  3'd0},
    '{8'h36, 1'b0, GRP_COIN,  3'd1},
    '{8'h75, 1'b1, GRP_P0,    3'd0},
    '{8'h72, 1'b1, GRP_P0,    3'd1},
    '{8'h6B, 1'b1, GRP_P0,    3'd2},
    '{8'h74, 1'b1, GRP_P0,    3'd3},
    '{8'h14, 1'b0, GRP_P0,    3'd4},
    '{8'h11, 1'b0, GRP_P0,    3'd5},
    '{8'h46, 1'b0, GRP_SYS,   3'd0},
    '{8'h4D, 1'b0, GRP_SYS,   3'd1}
  };

endpackage

// File: rtl/input_pulse_shaper.sv
// Per-player output shaping: coin-pulse stretcher (down-counter reloaded on
// each rising coin edge) and autofire gating of the fire buttons.
module input_pulse_shaper
  import input_map_pkg::*;
#(
  parameter int              NUM_BUTTONS = 2,
  parameter logic [COIN_W-1:0] COIN_PULSE = 20'd491520
) (
  input  logic                   clk_49m,
  input  logic                   reset,
  input  logic                   coin_in,
  input  logic [NUM_BUTTONS-1:0] btn_in,
  input  logic [NUM_BUTTONS-1:0] autofire_en,
  input  logic                   af_phase,
  output logic                   coin_out,
  output logic [NUM_BUTTONS-1:0] btn_out
);

  logic                   coin_prev_q, coin_prev_d;
  logic [COIN_W-1:0]      coin_cnt_q, coin_cnt_d;
  logic                   coin_out_q, coin_out_d;
  logic [NUM_BUTTONS-1:0] btn_out_q, btn_out_d;

  always_comb begin
    coin_prev_d = coin_in;
    coin_cnt_d  = coin_cnt_q;
    if (coin_in && !coin_prev_q) begin
      coin_cnt_d = COIN_PULSE;
    end else if (coin_cnt_q != '0) begin
      coin_cnt_d = coin_cnt_q - 1'b1;
    end
    coin_out_d = coin_in | (coin_cnt_q != '0);
    btn_out_d  = btn_in & (~autofire_en | {NUM_BUTTONS{af_phase}});
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      coin_prev_q <= 1'b0;
      coin_cnt_q  <= '0;
      coin_out_q  <= 1'b0;
      btn_out_q   <= '0;
    end else begin
      coin_prev_q <= coin_prev_d;
      coin_cnt_q  <= coin_cnt_d;
      coin_out_q  <= coin_out_d;
      btn_out_q   <= btn_out_d;
    end
  end

  assign coin_out = coin_out_q;
  assign btn_out  = btn_out_q;

endmodule

// File: rtl/arcade_input_mapper.sv
// Arcade control-input front end: PS/2 keymap scan (loadable via ioctl, with a
// built-in default), joystick merge, coin stretch and autofire.
//
// state    | meaning
// ST_IDLE  | waiting for a ps2_key toggle
// ST_SCAN  | visiting one keymap entry per cycle, accumulating the hit mask
// ST_APPLY | writing the pressed flag into every hit key-state bit
module arcade_input_mapper
  import input_map_pkg::*;
#(
  parameter int                NUM_PLAYERS  = 2,
  parameter int                NUM_BUTTONS  = 2,
  parameter int                KEYMAP_DEPTH = 32,
  parameter logic [7:0]        KEYMAP_INDEX = 8'd3,
  parameter logic [COIN_W-1:0] COIN_PULSE   = 20'd491520,
  parameter logic [AF_W-1:0]   AUTOFIRE_DIV = 22'd1638400
) (
  input  logic                               clk_49m,
  input  logic                               reset,
  input  logic [10:0]                        ps2_key,
  input  logic [16*NUM_PLAYERS-1:0]          joy_in,
  input  logic                               ioctl_wr,
  input  logic [7:0]                         ioctl_index,
  input  logic [24:0]                        ioctl_addr,
  input  logic [7:0]                         ioctl_dout,
  input  logic [NUM_BUTTONS-1:0]             autofire_en,
  output logic [4*NUM_PLAYERS-1:0]           p_dir,
  output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] p_btn,
  output logic [NUM_PLAYERS-1:0]             p_start,
  output logic [NUM_PLAYERS-1:0]             p_coin,
  output logic                               service,
  output logic                               pause,
  output logic                               map_loaded,
  output logic                               scan_busy
);

  localparam int NP      = NUM_PLAYERS;
  localparam int NB      = NUM_BUTTONS;
  localparam int AW      = $clog2(KEYMAP_DEPTH);
  localparam int DIR_O   = 0;
  localparam int BTN_O   = 4*NP;
  localparam int START_O = BTN_O + NB*NP;
  localparam int COIN_O  = START_O + NP;
  localparam int SVC_O   = COIN_O + NP;
  localparam int PAUSE_O = SVC_O + 1;
  localparam int CW      = PAUSE_O + 1;

  function automatic logic [CW-1:0] ctrl_onehot(input logic [5:0] idx);
    logic [CW-1:0] v;
    v = '0;
    for (int p = 0; p < NP; p++) begin
      if (idx == 6'(CTRL_STRIDE*p) + CTRL_U) v[DIR_O+4*p+3] = 1'b1;
      if (idx == 6'(CTRL_STRIDE*p) + CTRL_D) v[DIR_O+4*p+2] = 1'b1;
      if (idx == 6'(CTRL_STRIDE*p) + CTRL_L) v[DIR_O+4*p+1] = 1'b1;
      if (idx == 6'(CTRL_STRIDE*p) + CTRL_R) v[DIR_O+4*p]   = 1'b1;
      for (int b = 0; b < NB; b++)
        if (idx == 6'(CTRL_STRIDE*p + b) + CTRL_BTN0) v[BTN_O+NB*p+b] = 1'b1;
      if (idx == 6'(8*NP + p)) v[COIN_O+p]  = 1'b1;
      if (idx == 6'(9*NP + p)) v[START_O+p] = 1'b1;
    end
    if (idx == 6'(10*NP))     v[SVC_O]   = 1'b1;
    if (idx == 6'(10*NP + 1)) v[PAUSE_O] = 1'b1;
    return v;
  endfunction

  // start/coin defaults beyond NUM_PLAYERS would alias service/pause, so drop them.
  function automatic km_entry_t dflt_entry(input dflt_entry_t d);
    km_entry_t e;
    e.valid = 1'b1;
    e.ext   = d.ext;
    e.idx   = {3'b000, d.sub};
    case (d.grp)
      GRP_P0:    e.idx = {3'b000, d.sub};
      GRP_START: begin e.idx = 6'(9*NP) + {3'b000, d.sub}; e.valid = int'(d.sub) < NP; end
      GRP_COIN:  begin e.idx = 6'(8*NP) + {3'b000, d.sub}; e.valid = int'(d.sub) < NP; end
      GRP_SYS:   e.idx = 6'(10*NP) + {3'b000, d.sub};
    endcase
    return e;
  endfunction

  scan_state_e state_q, state_d;
  logic [AW-1:0] scan_idx_q, scan_idx_d;
  logic [CW-1:0] hit_q, hit_d, key_state_q, key_state_d;
  key_event_t    ev_q, ev_d, pend_q, pend_d, new_ev;
  logic          pend_vld_q, pend_vld_d, tog_q, tog_d, armed_q, armed_d;
  logic          busy_q, busy_d, loaded_q, loaded_d;
  logic [KEYMAP_DEPTH-1:0][7:0] tbl_code_q, tbl_code_d;
  km_entry_t [KEYMAP_DEPTH-1:0] tbl_ent_q, tbl_ent_d;
  logic          toggle, wr_ok;
  logic [7:0]    cur_code;
  km_entry_t     cur_ent;

  logic [CW-1:0]    joy_ctrl, merged;
  logic             unused_joy, any_af;
  logic [4*NP-1:0]  dir_q, dir_d;
  logic [NP-1:0]    start_q, start_d;
  logic             svc_q, svc_d, pause_q, pause_d;
  logic [AF_W-1:0]  af_cnt_q, af_cnt_d;
  logic             af_phase_q, af_phase_d;

  always_comb begin
    wr_ok      = ioctl_wr && (ioctl_index == KEYMAP_INDEX) && (ioctl_addr < 25'(2*KEYMAP_DEPTH));
    tbl_code_d = tbl_code_q;
    tbl_ent_d  = tbl_ent_q;
    loaded_d   = loaded_q | wr_ok;
    if (wr_ok) begin
      if (ioctl_addr[0]) tbl_ent_d[ioctl_addr[AW:1]]  = km_entry_t'(ioctl_dout);
      else               tbl_code_d[ioctl_addr[AW:1]] = ioctl_dout;
    end
  end

  // With KEYMAP_DEPTH below DEFAULT_N only the leading defaults are reachable.
  always_comb begin
    cur_code = '0;
    cur_ent  = '0;
    if (loaded_q) begin
      cur_code = tbl_code_q[scan_idx_q];
      cur_ent  = tbl_ent_q[scan_idx_q];
    end else begin
      for (int i = 0; i < DEFAULT_N; i++) begin
        if (int'(scan_idx_q) == i) begin
          cur_code = DEFAULT_MAP[i].code;
          cur_ent  = dflt_entry(DEFAULT_MAP[i]);
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    scan_idx_d  = scan_idx_q;
    hit_d       = hit_q;
    key_state_d = key_state_q;
    ev_d        = ev_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    tog_d       = ps2_key[10];
    armed_d     = 1'b1;
    new_ev      = key_event_t'(ps2_key[9:0]);
    toggle      = armed_q && (ps2_key[10] != tog_q);
    case (state_q)
      ST_IDLE: begin
        if (toggle) begin
          ev_d       = new_ev;
          hit_d      = '0;
          scan_idx_d = '0;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (toggle) begin
          pend_d     = new_ev;
          pend_vld_d = 1'b1;
        end
        if (cur_ent.valid && cur_ent.ext == ev_q.ext && cur_code == ev_q.code)
          hit_d = hit_q | ctrl_onehot(cur_ent.idx);
        if (scan_idx_q == AW'(KEYMAP_DEPTH-1)) state_d = ST_APPLY;
        else scan_idx_d = scan_idx_q + 1'b1;
      end
      ST_APPLY: begin
        key_state_d = ev_q.pressed ? (key_state_q | hit_q) : (key_state_q & ~hit_q);
        pend_vld_d  = 1'b0;
        hit_d       = '0;
        scan_idx_d  = '0;
        if (toggle || pend_vld_q) begin
          ev_d    = toggle ? new_ev : pend_q;
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_comb begin
    joy_ctrl   = '0;
    unused_joy = 1'b0;
    any_af     = 1'b0;
    for (int p = 0; p < NP; p++) begin
      joy_ctrl[DIR_O+4*p +: 4]   = joy_in[16*p +: 4];
      joy_ctrl[BTN_O+NB*p +: NB] = joy_in[16*p+4 +: NB];
      joy_ctrl[START_O+p]        = joy_in[16*p+4+NB];
      joy_ctrl[COIN_O+p]         = joy_in[16*p+5+NB];
      joy_ctrl[PAUSE_O]          = joy_ctrl[PAUSE_O] | joy_in[16*p+6+NB];
      for (int b = 7+NB; b < 16; b++) unused_joy = unused_joy ^ joy_in[16*p+b];
    end
    merged = key_state_q | joy_ctrl;
    for (int p = 0; p < NP; p++)
      any_af = any_af | (|(merged[BTN_O+NB*p +: NB] & autofire_en));
    dir_d   = merged[DIR_O +: 4*NP];
    start_d = merged[START_O +: NP];
    svc_d   = merged[SVC_O];
    pause_d = merged[PAUSE_O];
    if (!any_af) begin
      af_cnt_d   = '0;
      af_phase_d = 1'b1;
    end else if (af_cnt_q == AUTOFIRE_DIV - 1'b1) begin
      af_cnt_d   = '0;
      af_phase_d = ~af_phase_q;
    end else begin
      af_cnt_d   = af_cnt_q + 1'b1;
      af_phase_d = af_phase_q;
    end
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      scan_idx_q  <= '0;
      hit_q       <= '0;
      key_state_q <= '0;
      ev_q        <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      tog_q       <= 1'b0;
      armed_q     <= 1'b0;
      busy_q      <= 1'b0;
      loaded_q    <= 1'b0;
      tbl_code_q  <= '0;
      tbl_ent_q   <= '0;
      dir_q       <= '0;
      start_q     <= '0;
      svc_q       <= 1'b0;
      pause_q     <= 1'b0;
      af_cnt_q    <= '0;
      af_phase_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      scan_idx_q  <= scan_idx_d;
      hit_q       <= hit_d;
      key_state_q <= key_state_d;
      ev_q        <= ev_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      tog_q       <= tog_d;
      armed_q     <= armed_d;
      busy_q      <= busy_d;
      loaded_q    <= loaded_d;
      tbl_code_q  <= tbl_code_d;
      tbl_ent_q   <= tbl_ent_d;
      dir_q       <= dir_d;
      start_q     <= start_d;
      svc_q       <= svc_d;
      pause_q     <= pause_d;
      af_cnt_q    <= af_cnt_d;
      af_phase_q  <= af_phase_d;
    end
  end

  for (genvar p = 0; p < NP; p++) begin : g_player
    input_pulse_shaper #(
      .NUM_BUTTONS (NB),
      .COIN_PULSE  (COIN_PULSE)
    ) u_shaper (
      .clk_49m     (clk_49m),
      .reset       (reset),
      .coin_in     (merged[COIN_O+p]),
      .btn_in      (merged[BTN_O+NB*p +: NB]),
      .autofire_en (autofire_en),
      .af_phase    (af_phase_q),
      .coin_out    (p_coin[p]),
      .btn_out     (p_btn[NB*p +: NB])
    );
  end

  assign p_dir      = dir_q;
  assign p_start    = start_q;
  assign service    = svc_q;
  assign pause      = pause_q;
  assign map_loaded = loaded_q;
  assign scan_busy  = busy_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper with short coin/autofire timers.
module tb_arcade_input_mapper;

  localparam int NP  = 2;
  localparam int NB  = 2;
  localparam int CP  = 20;
  localparam int AFD = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] ps2_key;
  logic [31:0] joy_in;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [1:0]  autofire_en;
  logic [7:0]  p_dir;
  logic [3:0]  p_btn;
  logic [1:0]  p_start, p_coin;
  logic        service, pause, map_loaded, scan_busy;

  int n_cmp = 0;
  int n_err = 0;
  logic tog_bit = 1'b0;
  int len;

  always #5 clk = ~clk;

  arcade_input_mapper #(
    .NUM_PLAYERS  (NP),
    .NUM_BUTTONS  (NB),
    .KEYMAP_DEPTH (32),
    .KEYMAP_INDEX (8'd3),
    .COIN_PULSE   (20'(CP)),
    .AUTOFIRE_DIV (22'(AFD))
  ) dut (
    .clk_49m     (clk),
    .reset       (rst_n),
    .ps2_key     (ps2_key),
    .joy_in      (joy_in),
    .ioctl_wr    (ioctl_wr),
    .ioctl_index (ioctl_index),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .autofire_en (autofire_en),
    .p_dir       (p_dir),
    .p_btn       (p_btn),
    .p_start     (p_start),
    .p_coin      (p_coin),
    .service     (service),
    .pause       (pause),
    .map_loaded  (map_loaded),
    .scan_busy   (scan_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
    tog_bit = ~tog_bit;
    ps2_key = {tog_bit, pressed, ext, code};
  endtask

  task automatic km_write(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
    ioctl_wr = 1'b1; ioctl_index = idx; ioctl_addr = addr; ioctl_dout = data;
    @(negedge clk);
    ioctl_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic coin_len(input int gap, output int n);
    joy_in[5+NB] = 1'b1;
    @(negedge clk);
    joy_in[5+NB] = 1'b0;
    n = 0;
    for (int j = 0; j < 300; j++) begin
      if (!p_coin[0]) break;
      n++;
      if (gap > 1 && j == gap-1) joy_in[5+NB] = 1'b1;
      if (gap > 1 && j == gap)   joy_in[5+NB] = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ps2_key = '0; joy_in = '0; ioctl_wr = 1'b0;
    ioctl_index = '0; ioctl_addr = '0; ioctl_dout = '0; autofire_en = '0;
    repeat (3) @(negedge clk);
    chk("rst_dir", p_dir, 0);
    chk("rst_btn", p_btn, 0);
    chk("rst_coin", p_coin, 0);
    chk("rst_loaded", map_loaded, 0);
    chk("rst_busy", scan_busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Default map: cursor up, 35-cycle latency
    send_key(1'b1, 1'b1, 8'h75);
    @(negedge clk);
    chk("up_busy", scan_busy, 1);
    repeat (33) @(negedge clk);
    chk("up_early", p_dir, 8'h00);
    @(negedge clk);
    chk("up_set", p_dir, 8'h08);
    send_key(1'b0, 1'b1, 8'h75);
    repeat (35) @(negedge clk);
    chk("up_clr", p_dir, 8'h00);

    send_key(1'b1, 1'b0, 8'h46);
    repeat (35) @(negedge clk);
    chk("svc_set", service, 1);
    send_key(1'b0, 1'b0, 8'h46);
    repeat (35) @(negedge clk);
    chk("svc_clr", service, 0);

    // Second toggle arrives mid-scan and is applied after the first APPLY
    send_key(1'b1, 1'b0, 8'h14);
    repeat (5) @(negedge clk);
    send_key(1'b1, 1'b0, 8'h11);
    repeat (30) @(negedge clk);
    chk("pend_first", p_btn, 4'b0001);
    repeat (32) @(negedge clk);
    chk("pend_early", p_btn, 4'b0001);
    @(negedge clk);
    chk("pend_second", p_btn, 4'b0011);
    send_key(1'b0, 1'b0, 8'h14);
    repeat (40) @(negedge clk);
    send_key(1'b0, 1'b0, 8'h11);
    repeat (40) @(negedge clk);
    chk("pend_rel", p_btn, 4'b0000);

    // Joystick merge: one cycle latency, pause OR across players
    joy_in[16+3] = 1'b1; joy_in[16+4+NB] = 1'b1; joy_in[16+6+NB] = 1'b1;
    @(negedge clk);
    chk("joy_dir", p_dir, 8'h80);
    chk("joy_start", p_start, 2'b10);
    chk("joy_pause", pause, 1);
    joy_in = '0;
    @(negedge clk);
    chk("joy_clr", p_dir, 8'h00);

    // Coin stretch
    coin_len(0, len);
    chk("coin_single", len, CP+1);
    chk("coin_p1", p_coin[1], 0);
    repeat (3) @(negedge clk);
    coin_len(10, len);
    chk("coin_retrig", len, 10+CP+1);

    // Autofire on btn0 only
    autofire_en = 2'b01;
    joy_in[4] = 1'b1; joy_in[5] = 1'b1;
    for (int j = 0; j < 4*AFD; j++) begin
      @(negedge clk);
      chk("af_b0", p_btn[0], ((j/AFD) % 2) == 0);
      chk("af_b1", p_btn[1], 1);
    end
    joy_in = '0; autofire_en = '0;
    repeat (2) @(negedge clk);
    chk("af_rel", p_btn, 4'b0000);

    // Keymap download
    km_write(8'd0, 25'd0, 8'h1C);
    chk("km_wrong_idx", map_loaded, 0);
    km_write(8'd3, 25'd64, 8'h55);
    chk("km_addr_oor", map_loaded, 0);
    km_write(8'd3, 25'd0, 8'h1C);
    chk("km_loaded", map_loaded, 1);
    km_write(8'd3, 25'd1, 8'h8C);
    send_key(1'b1, 1'b0, 8'h1C);
    repeat (34) @(negedge clk);
    chk("km_early", p_btn, 4'b0000);
    @(negedge clk);
    chk("km_p1b0", p_btn, 4'b0100);
    send_key(1'b0, 1'b0, 8'h1C);
    repeat (35) @(negedge clk);
    chk("km_rel", p_btn, 4'b0000);
    send_key(1'b1, 1'b1, 8'h75);
    repeat (36) @(negedge clk);
    chk("km_no_default", p_dir, 8'h00);
    send_key(1'b0, 1'b1, 8'h75);
    repeat (36) @(negedge clk);

    // Reset during a scan
    joy_in[0] = 1'b1;
    send_key(1'b1, 1'b0, 8'h1C);
    repeat (10) @(negedge clk);
    chk("mid_busy", scan_busy, 1);
    chk("mid_dir", p_dir, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("mrst_dir", p_dir, 0);
    chk("mrst_btn", p_btn, 0);
    chk("mrst_busy", scan_busy, 0);
    chk("mrst_loaded", map_loaded, 0);
    joy_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_btn", p_btn, 0);
    chk("post_busy", scan_busy, 0);
    send_key(1'b1, 1'b1, 8'h75);
    repeat (35) @(negedge clk);
    chk("post_default", p_dir, 8'h08);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
Parametrised control-input front end for arcade cores. It replaces the hard-coded per-core PS/2 keyboard case decode and joystick OR-ing. A scancode-to-control keymap can be loaded through ioctl; until one is loaded, a built-in default map is used. It also adds coin-pulse stretching and per-button autofire. The block sits between hps_io and the core top-level and produces registered, active-high control vectors that the emu wrapper inverts as the core requires.

Parameters:
NUM_PLAYERS, 2, number of player channels (1..4)
NUM_BUTTONS, 2, fire buttons per player (1..4)
KEYMAP_DEPTH, 32, keymap table entries (power of 2, 8..64)
KEYMAP_INDEX, 8'd3, ioctl_index that selects keymap download
COIN_PULSE, 20'd491520, minimum coin-high length in clk cycles (10 ms at 49.152 MHz)
AUTOFIRE_DIV, 22'd1638400, clk cycles per autofire half-period

Ports:
clk_49m  in  1  system clock
reset  in  1  asynchronous, active-low reset
ps2_key  in  11  [10] toggle, [9] pressed, [8] extended, [7:0] scancode
joy_in  in  16*NUM_PLAYERS  per player: [0]R [1]L [2]D [3]U [4+:NUM_BUTTONS] fire, then start, coin, pause
ioctl_wr  in  1  download write strobe
ioctl_index  in  8  download index
ioctl_addr  in  25  download byte address
ioctl_dout  in  8  download data
autofire_en  in  NUM_BUTTONS  per-button autofire enable, applies to all players
p_dir  out  4*NUM_PLAYERS  per player {U,D,L,R}
p_btn  out  NUM_BUTTONS*NUM_PLAYERS  fire buttons after autofire
p_start  out  NUM_PLAYERS  start buttons
p_coin  out  NUM_PLAYERS  stretched coin
service  out  1  service button
pause  out  1  pause request
map_loaded  out  1  high once any keymap byte has been written
scan_busy  out  1  high while a key event is being resolved

Behaviour:
- Reset: all outputs 0, all key-state bits 0, all table valid bits 0, map_loaded 0, FSM in IDLE.
- Control index space (6 bits): player p occupies 8*p+{0 U, 1 D, 2 L, 3 R, 4..7 btn0..3}. After the player slots come coin[p] at 8*NP+p, start[p] at 9*NP+p, service at 10*NP, pause at 10*NP+1. Indices that are out of range or name a button >= NUM_BUTTONS are ignored.
- Keymap entry e occupies two bytes. Byte 2e is the scancode. Byte 2e+1 is {valid, ext, idx[5:0]}. A write is accepted when ioctl_wr, ioctl_index==KEYMAP_INDEX and ioctl_addr < 2*KEYMAP_DEPTH. The first accepted write sets map_loaded. Entries that are never written stay invalid.
- Default map, used while map_loaded==0: 1=start0, 2=start1, 5=coin0, 6=coin1, 9=service, P=pause, and cursor keys, ctrl and alt map to U/D/L/R/btn0/btn1 of player 0.
- FSM IDLE -> SCAN -> APPLY -> IDLE.
  - A change of ps2_key[10] in IDLE latches {pressed, ext, code} and enters SCAN.
  - SCAN visits one entry per cycle for all KEYMAP_DEPTH entries, with no early exit. Each matching entry sets a bit in a hit mask.
  - APPLY writes pressed into every key-state bit that is set in the hit mask.
  - Latency from the toggle edge to an updated output is KEYMAP_DEPTH+3 cycles.
  - scan_busy is high during SCAN and APPLY.
- A toggle that arrives while busy is captured in a one-deep pending register and processed immediately after APPLY. A further toggle overwrites the pending event, so the last event wins.
- A keymap write during SCAN takes effect for the entries that have not yet been scanned. No stall is applied.
- Merge: ctrl = key_state | joy_in-derived bits. The pause output ORs the pause bits of all players. Outputs are registered, giving one cycle of latency from joy_in.
- Coin stretch per player:
  - A rising edge of the merged coin loads a 20-bit counter with COIN_PULSE.
  - p_coin = merged coin OR (counter != 0).
  - A new rising edge during the count reloads the counter.
- Autofire:
  - A free-running counter toggles a phase bit every AUTOFIRE_DIV cycles.
  - The counter and phase are held at 0/phase=1 while no autofire-enabled button is pressed on any player, so the first press is output immediately.
  - An enabled button outputs held AND phase. A disabled button outputs held.
- Reset asserted mid-scan aborts the scan and clears the pending event and all state. Table contents are not guaranteed after reset, so valid is cleared.

Decomposition:
- Shared package input_map_pkg holds:
  - the control-index localparams (CTRL_U..CTRL_BTN3, per-player stride 8);
  - the keymap entry struct {valid, ext, idx};
  - the default map as a constant array of 12 entries.
- One natural sub-module, input_pulse_shaper, instantiated once per player. It contains the coin stretcher plus autofire gating of the button vector, with the phase supplied from the top.

Test Plan:
- Default map, no download: a ps2_key toggle with code 0x75 pressed sets p_dir[3] exactly 35 cycles later (DEPTH=32). A release toggle clears it.
- Load entry 0 = {0x1C, 8'b1_0_001100} (A -> player1 btn0): a press of 0x1C sets p_btn[NUM_BUTTONS+0]; map_loaded=1; 0x75 no longer has any effect.
- Two toggles 5 cycles apart (press 0x14, then press 0x11): both p_btn[0] and p_btn[1] end up set, the second applied after the first APPLY completes.
- A 1-cycle joy_in coin pulse on player 0 gives p_coin[0] high for exactly COIN_PULSE+1 cycles. A second pulse mid-count extends the pulse from that point.
- autofire_en=01 with btn0 held via joystick: p_btn[0] high for AUTOFIRE_DIV cycles, then low for AUTOFIRE_DIV cycles, repeating, starting high on the first cycle. btn1 stays steady.
- Assert reset during SCAN: all outputs are 0 on the next cycle, FSM is in IDLE, and map_loaded=0.
